// File: rtl/if_id_stall_seq_if.sv
// Stall/fetch/decode handshake bundle for if_id_stall_seq.
// STALL_STATS_EN adds the stall_cycles statistics signal.
interface if_id_stall_seq_if #(
  parameter int INSTR_W = 16
);
  logic [1:0]         stall_c;
  logic               wrt_IF_ID;
  logic               flush;
  logic [INSTR_W-1:0] instr_in;
  logic [INSTR_W-1:0] pc_p2_in;
  logic               pc_en;
  logic [INSTR_W-1:0] if_id_instr;
  logic [INSTR_W-1:0] if_id_pc_p2;
  logic               if_id_valid;
  logic               id_ex_bubble;
  logic               stall_err;
`ifdef STALL_STATS_EN
  logic [15:0]        stall_cycles;

  modport master (
    output stall_c, wrt_IF_ID, flush, instr_in, pc_p2_in,
    input  pc_en, if_id_instr, if_id_pc_p2, if_id_valid, id_ex_bubble, stall_err,
    input  stall_cycles
  );

  modport slave (
    input  stall_c, wrt_IF_ID, flush, instr_in, pc_p2_in,
    output pc_en, if_id_instr, if_id_pc_p2, if_id_valid, id_ex_bubble, stall_err,
    output stall_cycles
  );
`else
  modport master (
    output stall_c, wrt_IF_ID, flush, instr_in, pc_p2_in,
    input  pc_en, if_id_instr, if_id_pc_p2, if_id_valid, id_ex_bubble, stall_err
  );

  modport slave (
    input  stall_c, wrt_IF_ID, flush, instr_in, pc_p2_in,
    output pc_en, if_id_instr, if_id_pc_p2, if_id_valid, id_ex_bubble, stall_err
  );
`endif
endinterface

// File: rtl/if_id_stall_seq.sv
// IF/ID pipeline register with hazard stall sequencing and flush priority.
// Optional STALL_STATS_EN adds a saturating count of PC-hold cycles.
//
// state | meaning
// RUN   | normal flow; same-cycle stall for any non-zero request length
// HOLD  | second cycle of a two-cycle stall; new requests ignored
module if_id_stall_seq #(
  parameter int                 INSTR_W = 16,
  parameter logic [INSTR_W-1:0] NOP     = 'h0800
) (
  input  logic              clk,
  input  logic              rst,
  if_id_stall_seq_if.slave  bus
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t             state;
  logic               cnt;
  logic [INSTR_W-1:0] instr_q;
  logic [INSTR_W-1:0] pc_p2_q;
  logic               valid_q;
  logic               err_q;

  logic [1:0]         req_len;
  logic               req_illegal;
  logic               hold_active;
  logic               pc_en_c;
  logic               bubble_c;

  always_comb begin
    req_len = 2'd0;
    unique case (bus.stall_c)
      2'b00:   req_len = bus.wrt_IF_ID ? 2'd0 : 2'd1;
      2'b01:   req_len = 2'd1;
      default: req_len = 2'd2;
    endcase
  end

  assign req_illegal = (bus.stall_c == 2'b11) || ((bus.stall_c != 2'b00) && bus.wrt_IF_ID);

  // A HOLD with an exhausted count behaves like RUN so a corrupted cnt cannot wedge fetch.
  assign hold_active = (state == HOLD) && (cnt != 1'b0);

  always_comb begin
    pc_en_c  = 1'b0;
    bubble_c = 1'b1;
    if (rst) begin
      pc_en_c  = 1'b0;
      bubble_c = 1'b1;
    end else if (bus.flush) begin
      pc_en_c  = 1'b1;
      bubble_c = 1'b1;
    end else if (hold_active) begin
      pc_en_c  = 1'b0;
      bubble_c = 1'b1;
    end else begin
      pc_en_c  = (req_len == 2'd0);
      bubble_c = (req_len != 2'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= 1'b0;
      instr_q <= NOP;
      pc_p2_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (req_illegal) begin
        err_q <= 1'b1;
      end
      if (bus.flush) begin
        state   <= RUN;
        cnt     <= 1'b0;
        instr_q <= NOP;
        valid_q <= 1'b0;
      end else if (hold_active) begin
        state <= RUN;
        cnt   <= 1'b0;
      end else begin
        unique case (req_len)
          2'd0: begin
            state   <= RUN;
            cnt     <= 1'b0;
            instr_q <= bus.instr_in;
            pc_p2_q <= bus.pc_p2_in;
            valid_q <= 1'b1;
          end
          2'd1: begin
            state <= RUN;
            cnt   <= 1'b0;
          end
          default: begin
            state <= HOLD;
            cnt   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.pc_en        = pc_en_c;
  assign bus.id_ex_bubble = bubble_c;
  assign bus.if_id_instr  = instr_q;
  assign bus.if_id_pc_p2  = pc_p2_q;
  assign bus.if_id_valid  = valid_q;
  assign bus.stall_err    = err_q;

`ifdef STALL_STATS_EN
  logic [15:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if (!pc_en_c && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_q <= stall_cycles_q + 16'd1;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_if_id_stall_seq.sv
// Self-checking bench for if_id_stall_seq: directed scenarios plus randomized traffic
// checked every cycle against a stall-budget model. Build with STALL_STATS_EN to cover the counter.
module tb_if_id_stall_seq;

  localparam int          W   = 16;
  localparam logic [15:0] NOP = 16'h0800;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_id_stall_seq_if #(.INSTR_W(W)) bus ();

  if_id_stall_seq #(.INSTR_W(W), .NOP(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: registers as decode sees them, plus how many more cycles are owed to a stall.
  bit          model_ok = 1'b0;
  logic [15:0] m_instr;
  logic [15:0] m_pc;
  logic        m_valid;
  logic        m_err;
  int          m_rem;
  int          m_stats;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int req_len(input logic [1:0] sc, input logic w);
    if (sc == 2'b00) return w ? 0 : 1;
    if (sc == 2'b01) return 1;
    return 2;
  endfunction

  function automatic bit exp_pc_en();
    if (rst) return 1'b0;
    if (bus.flush) return 1'b1;
    if (m_rem > 0) return 1'b0;
    return req_len(bus.stall_c, bus.wrt_IF_ID) == 0;
  endfunction

  function automatic bit exp_bubble();
    if (rst || bus.flush || m_rem > 0) return 1'b1;
    return req_len(bus.stall_c, bus.wrt_IF_ID) != 0;
  endfunction

  task automatic compare_all();
    if (!model_ok) return;
    chk("pc_en",        {31'd0, bus.pc_en},        {31'd0, exp_pc_en()});
    chk("id_ex_bubble", {31'd0, bus.id_ex_bubble}, {31'd0, exp_bubble()});
    chk("if_id_instr",  {16'd0, bus.if_id_instr},  {16'd0, m_instr});
    chk("if_id_pc_p2",  {16'd0, bus.if_id_pc_p2},  {16'd0, m_pc});
    chk("if_id_valid",  {31'd0, bus.if_id_valid},  {31'd0, m_valid});
    chk("stall_err",    {31'd0, bus.stall_err},    {31'd0, m_err});
`ifdef STALL_STATS_EN
    chk("stall_cycles", {16'd0, bus.stall_cycles}, m_stats);
`endif
  endtask

  task automatic model_update();
    int len;
    if (rst) begin
      m_instr  = NOP;
      m_pc     = '0;
      m_valid  = 1'b0;
      m_err    = 1'b0;
      m_rem    = 0;
      m_stats  = 0;
      model_ok = 1'b1;
      return;
    end
    if (!model_ok) return;
    if (bus.stall_c == 2'b11 || (bus.stall_c != 2'b00 && bus.wrt_IF_ID)) m_err = 1'b1;
    if (!exp_pc_en() && m_stats < 65535) m_stats++;
    len = req_len(bus.stall_c, bus.wrt_IF_ID);
    if (bus.flush) begin
      m_instr = NOP;
      m_valid = 1'b0;
      m_rem   = 0;
    end else if (m_rem > 0) begin
      m_rem--;
    end else if (len == 0) begin
      m_instr = bus.instr_in;
      m_pc    = bus.pc_p2_in;
      m_valid = 1'b1;
    end else begin
      m_rem = len - 1;
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
  task automatic set_in(input logic r, input logic [1:0] sc, input logic w, input logic f,
                        input logic [15:0] ins, input logic [15:0] pc);
    rst           = r;
    bus.stall_c   = sc;
    bus.wrt_IF_ID = w;
    bus.flush     = f;
    bus.instr_in  = ins;
    bus.pc_p2_in  = pc;
    #2;
  endtask

  task automatic step();
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle(input logic [15:0] ins);
    set_in(1'b0, 2'b00, 1'b1, 1'b0, ins, ins + 16'd2);
  endtask

  initial begin
    logic [1:0]  sc;
    logic        w, f, r;
    logic [15:0] ins;
    int          x;

    // Reset held for two cycles.
    set_in(1'b1, 2'b00, 1'b1, 1'b0, 16'h0000, 16'h0000); step();
    set_in(1'b1, 2'b00, 1'b1, 1'b0, 16'h0000, 16'h0000);
    chk("rst_pc_en",  {31'd0, bus.pc_en},        32'd0);
    chk("rst_bubble", {31'd0, bus.id_ex_bubble}, 32'd1);
    chk("rst_instr",  {16'd0, bus.if_id_instr},  32'h0800);
    chk("rst_valid",  {31'd0, bus.if_id_valid},  32'd0);
    step();

    // Free-running fetch.
    idle(16'h1111);
    chk("run_pc_en", {31'd0, bus.pc_en}, 32'd1);
    step();
    idle(16'h2222);
    chk("run_load1",  {16'd0, bus.if_id_instr}, 32'h1111);
    chk("run_pcp2",   {16'd0, bus.if_id_pc_p2}, 32'h1113);
    chk("run_valid1", {31'd0, bus.if_id_valid}, 32'd1);
    step();

    // One-cycle stall.
    set_in(1'b0, 2'b01, 1'b0, 1'b0, 16'hA123, 16'h0010);
    chk("s1_pc_en",  {31'd0, bus.pc_en},        32'd0);
    chk("s1_bubble", {31'd0, bus.id_ex_bubble}, 32'd1);
    chk("s1_instr",  {16'd0, bus.if_id_instr},  32'h2222);
    step();
    set_in(1'b0, 2'b00, 1'b1, 1'b0, 16'hA123, 16'h0010);
    chk("s1_resume", {31'd0, bus.pc_en},       32'd1);
    chk("s1_held",   {16'd0, bus.if_id_instr}, 32'h2222);
    step();
    idle(16'h3333);
    chk("s1_loaded", {16'd0, bus.if_id_instr}, 32'hA123);
    step();

    // Two-cycle stall, request during HOLD ignored.
    set_in(1'b0, 2'b10, 1'b0, 1'b0, 16'h4444, 16'h0020);
    chk("s2_c0_pc_en", {31'd0, bus.pc_en}, 32'd0);
    step();
    set_in(1'b0, 2'b01, 1'b0, 1'b0, 16'h4444, 16'h0020);
    chk("s2_c1_pc_en",  {31'd0, bus.pc_en},        32'd0);
    chk("s2_c1_bubble", {31'd0, bus.id_ex_bubble}, 32'd1);
    step();
    set_in(1'b0, 2'b00, 1'b1, 1'b0, 16'h4444, 16'h0020);
    chk("s2_resume", {31'd0, bus.pc_en},        32'd1);
    chk("s2_nobub",  {31'd0, bus.id_ex_bubble}, 32'd0);
    chk("s2_noerr",  {31'd0, bus.stall_err},    32'd0);
    step();

    // Flush during HOLD.
    set_in(1'b0, 2'b10, 1'b0, 1'b0, 16'h5555, 16'h0030); step();
    set_in(1'b0, 2'b00, 1'b1, 1'b1, 16'h5555, 16'h0030);
    chk("fl_pc_en",  {31'd0, bus.pc_en},        32'd1);
    chk("fl_bubble", {31'd0, bus.id_ex_bubble}, 32'd1);
    step();
    idle(16'h6666);
    chk("fl_instr", {16'd0, bus.if_id_instr},  32'h0800);
    chk("fl_valid", {31'd0, bus.if_id_valid},  32'd0);
    chk("fl_run",   {31'd0, bus.pc_en},        32'd1);
    step();

    // Illegal request: two-cycle stall and sticky error.
    set_in(1'b0, 2'b11, 1'b0, 1'b0, 16'h7777, 16'h0040);
    chk("il_pc_en", {31'd0, bus.pc_en}, 32'd0);
    step();
    idle(16'h7777);
    chk("il_hold", {31'd0, bus.pc_en},     32'd0);
    chk("il_err",  {31'd0, bus.stall_err}, 32'd1);
    step();
    for (int i = 0; i < 10; i++) begin
      idle(16'h8000 + 16'(i));
      step();
    end
    idle(16'h9999);
    chk("il_sticky", {31'd0, bus.stall_err}, 32'd1);
    step();
    set_in(1'b1, 2'b00, 1'b1, 1'b0, 16'h0, 16'h0); step();
    idle(16'h9999);
    chk("il_cleared", {31'd0, bus.stall_err}, 32'd0);
    step();

`ifdef STALL_STATS_EN
    set_in(1'b1, 2'b00, 1'b1, 1'b0, 16'h0, 16'h0); step();
    set_in(1'b0, 2'b01, 1'b0, 1'b0, 16'h0100, 16'h0); step();
    idle(16'h0101); step();
    set_in(1'b0, 2'b10, 1'b0, 1'b0, 16'h0102, 16'h0); step();
    idle(16'h0103); step();
    idle(16'h0104); step();
    set_in(1'b0, 2'b01, 1'b0, 1'b0, 16'h0105, 16'h0); step();
    idle(16'h0106);
    chk("stats_four", {16'd0, bus.stall_cycles}, 32'd4);
    step();
    for (int i = 0; i < 70000; i++) begin
      set_in(1'b0, 2'b01, 1'b0, 1'b0, 16'h0200, 16'h0);
      step();
    end
    idle(16'h0201);
    chk("stats_sat", {16'd0, bus.stall_cycles}, 32'h0000FFFF);
    step();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 63) == 0);
      f = ($urandom_range(0, 9) == 0);
      x = $urandom_range(0, 9);
      if (x < 5)      sc = 2'b00;
      else if (x < 7) sc = 2'b01;
      else if (x < 9) sc = 2'b10;
      else            sc = 2'b11;
      w   = (sc == 2'b00) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      ins = 16'($urandom());
      set_in(r, sc, w, f, ins, 16'($urandom()));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
